// File: rtl/change_dispenser.sv
// Change payout engine: greedy largest-first coin dispensing with per-denomination stock and hopper handshake.
// Latency: first coin request two cycles after start, then two cycles per coin minimum; a hopper that never acks aborts after HOPPER_TIMEOUT cycles.
module change_dispenser #(
    parameter int REFILL_COUNT   = 20,
    parameter int HOPPER_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] change_amount,
    input  logic       refill,
    input  logic       hopper_ack,
    output logic       coin_valid,
    output logic [3:0] coin_code,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] remaining,
    output logic [7:0] dispensed_total
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam int              TW       = $clog2(HOPPER_TIMEOUT + 1);
    localparam logic [TW-1:0]   TO_LAST  = TW'(HOPPER_TIMEOUT - 1);
    localparam logic [7:0]      REFILL8  = 8'(REFILL_COUNT);
    localparam logic [1:0]      FC_SHORT = 2'd1;
    localparam logic [1:0]      FC_TMO   = 2'd2;

    state_t             state;
    logic [3:0][7:0]    stock;      // index 0..3 = denominations 1, 5, 10, 50
    logic [1:0]         issue_idx;
    logic [TW-1:0]      tmo_cnt;
    logic               sel_vld;
    logic [1:0]         sel_idx;

    function automatic logic [7:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd0:    coin_value = 8'd1;
            2'd1:    coin_value = 8'd5;
            2'd2:    coin_value = 8'd10;
            default: coin_value = 8'd50;
        endcase
    endfunction

    // Ascending scan so the last qualifying denomination, i.e. the largest, wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (coin_value(2'(i)) <= remaining && stock[i] != 8'd0) begin
                sel_vld = 1'b1;
                sel_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            stock           <= {4{REFILL8}};
            issue_idx       <= 2'd0;
            tmo_cnt         <= '0;
            coin_valid      <= 1'b0;
            coin_code       <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            fault           <= 1'b0;
            fault_code      <= 2'd0;
            remaining       <= 8'd0;
            dispensed_total <= 8'd0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (refill) begin
                        stock <= {4{REFILL8}};
                    end
                    if (start) begin
                        remaining       <= change_amount;
                        dispensed_total <= 8'd0;
                        fault_code      <= 2'd0;
                        busy            <= 1'b1;
                        state           <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (remaining == 8'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (sel_vld) begin
                        issue_idx  <= sel_idx;
                        coin_valid <= 1'b1;
                        coin_code  <= {2'b00, sel_idx} + 4'd1;
                        tmo_cnt    <= '0;
                        state      <= S_ISSUE;
                    end else begin
                        fault      <= 1'b1;
                        fault_code <= FC_SHORT;
                        state      <= S_FAULT;
                    end
                end
                S_ISSUE: begin
                    if (hopper_ack) begin
                        remaining            <= remaining - coin_value(issue_idx);
                        dispensed_total      <= dispensed_total + coin_value(issue_idx);
                        stock[issue_idx]     <= stock[issue_idx] - 8'd1;
                        coin_valid           <= 1'b0;
                        coin_code            <= 4'd0;
                        state                <= S_SELECT;
                    end else if (tmo_cnt == TO_LAST) begin
                        coin_valid <= 1'b0;
                        coin_code  <= 4'd0;
                        fault      <= 1'b1;
                        fault_code <= FC_TMO;
                        state      <= S_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_DONE, S_FAULT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: instance 0 has full stock and a short hopper timeout,
// instance 1 has a single coin of each denomination for the short-payout case.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i [2];
    logic [7:0] amt_i   [2];
    logic       refill_i[2];
    logic       ack_i   [2];
    logic       cv      [2];
    logic [3:0] code    [2];
    logic       busy    [2];
    logic       done    [2];
    logic       fault   [2];
    logic [1:0] fcode   [2];
    logic [7:0] rem     [2];
    logic [7:0] disp    [2];

    int checks = 0;
    int passed = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    change_dispenser #(.REFILL_COUNT(20), .HOPPER_TIMEOUT(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .change_amount(amt_i[0]),
        .refill(refill_i[0]), .hopper_ack(ack_i[0]), .coin_valid(cv[0]), .coin_code(code[0]),
        .busy(busy[0]), .done(done[0]), .fault(fault[0]), .fault_code(fcode[0]),
        .remaining(rem[0]), .dispensed_total(disp[0])
    );

    change_dispenser #(.REFILL_COUNT(1), .HOPPER_TIMEOUT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .change_amount(amt_i[1]),
        .refill(refill_i[1]), .hopper_ack(ack_i[1]), .coin_valid(cv[1]), .coin_code(code[1]),
        .busy(busy[1]), .done(done[1]), .fault(fault[1]), .fault_code(fcode[1]),
        .remaining(rem[1]), .dispensed_total(disp[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] stock0(input int i);
        return dut0.stock[i];
    endfunction

    // Drives one payout on instance u and records what the DUT did, cycle by cycle.
    // cyc counts negedges after the start edge, so cyc==k means "at N+k".
    task automatic payout(input int u, input logic [7:0] amt, input bit do_ack, input bit inject,
                          output int n_done, output int n_fault, output int cv_cycles,
                          output int done_at, output int first_cv, output int busy1,
                          output int fault_with_cv);
        bit prev_cv = 0;
        bit finished = 0;
        n_done = 0; n_fault = 0; cv_cycles = 0; done_at = -1; first_cv = -1;
        busy1 = 0; fault_with_cv = 0;
        start_i[u] = 1'b1;
        amt_i[u]   = amt;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            @(negedge clk);
            start_i[u]  = 1'b0;
            refill_i[u] = 1'b0;
            ack_i[u]    = 1'b0;
            if (cyc == 1) busy1 = busy[u];
            if (cv[u]) begin
                cv_cycles++;
                if (first_cv < 0) first_cv = cyc;
                if (!prev_cv) begin
                    if (exp_q.size() == 0) chk("extra_coin", code[u], 4'd0);
                    else chk("coin_seq", code[u], exp_q.pop_front());
                end
                if (do_ack) ack_i[u] = 1'b1;
            end
            prev_cv = cv[u];
            if (done[u]) begin n_done++; done_at = cyc; end
            if (fault[u]) begin n_fault++; if (cv[u]) fault_with_cv++; end
            if (inject && cyc == 1) begin
                start_i[u]  = 1'b1;
                amt_i[u]    = 8'd99;
                refill_i[u] = 1'b1;
                ack_i[u]    = 1'b1;
            end
            if (cyc >= 2 && !busy[u] && !start_i[u]) finished = 1;
        end
        chk("payout_budget", {31'd0, finished}, 32'd1);
        chk("coins_missing", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int nd, nf, cvc, dat, fcv, b1, fwc;
        for (int u = 0; u < 2; u++) begin
            start_i[u] = 0; amt_i[u] = 0; refill_i[u] = 0; ack_i[u] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_coin_valid", cv[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_remaining", rem[0], 0);
        chk("rst_fault_code", fcode[0], 0);
        chk("rst_stock50", stock0(3), 20);
        rst_n = 1'b1;
        @(negedge clk);

        // 67 = 50 + 10 + 5 + 1 + 1
        exp_q.push_back(4'd4); exp_q.push_back(4'd3); exp_q.push_back(4'd2);
        exp_q.push_back(4'd1); exp_q.push_back(4'd1);
        payout(0, 8'd67, 1, 0, nd, nf, cvc, dat, fcv, b1, fwc);
        chk("p67_done_cnt", nd, 1);
        chk("p67_fault_cnt", nf, 0);
        chk("p67_busy_n1", b1, 1);
        chk("p67_first_cv", fcv, 2);
        chk("p67_done_at", dat, 12);
        chk("p67_cv_cycles", cvc, 5);
        chk("p67_remaining", rem[0], 0);
        chk("p67_dispensed", disp[0], 67);
        chk("p67_stock50", stock0(3), 19);
        chk("p67_stock10", stock0(2), 19);
        chk("p67_stock5", stock0(1), 19);
        chk("p67_stock1", stock0(0), 18);

        payout(0, 8'd0, 1, 0, nd, nf, cvc, dat, fcv, b1, fwc);
        chk("zero_done_at", dat, 2);
        chk("zero_cv_cycles", cvc, 0);
        chk("zero_dispensed", disp[0], 0);

        // Single coin of each kind: 20 pays 10, 5, 1 then runs short.
        exp_q.push_back(4'd3); exp_q.push_back(4'd2); exp_q.push_back(4'd1);
        payout(1, 8'd20, 1, 0, nd, nf, cvc, dat, fcv, b1, fwc);
        chk("short_fault_cnt", nf, 1);
        chk("short_done_cnt", nd, 0);
        chk("short_fault_code", fcode[1], 1);
        chk("short_remaining", rem[1], 4);
        chk("short_dispensed", disp[1], 16);
        payout(1, 8'd1, 1, 0, nd, nf, cvc, dat, fcv, b1, fwc);
        chk("short2_fault_cnt", nf, 1);
        chk("short2_fault_code", fcode[1], 1);
        chk("short2_cv_cycles", cvc, 0);

        exp_q.push_back(4'd2);
        payout(0, 8'd5, 0, 0, nd, nf, cvc, dat, fcv, b1, fwc);
        chk("tmo_cv_cycles", cvc, 8);
        chk("tmo_fault_cnt", nf, 1);
        chk("tmo_cv_on_fault", fwc, 0);
        chk("tmo_fault_code", fcode[0], 2);
        chk("tmo_stock5", stock0(1), 19);
        chk("tmo_remaining", rem[0], 5);

        // Busy-time start/refill/ack must all be ignored.
        exp_q.push_back(4'd3); exp_q.push_back(4'd1);
        payout(0, 8'd11, 1, 1, nd, nf, cvc, dat, fcv, b1, fwc);
        chk("ign_done_cnt", nd, 1);
        chk("ign_dispensed", disp[0], 11);
        chk("ign_fault_code", fcode[0], 0);
        chk("ign_stock10", stock0(2), 18);
        chk("ign_stock1", stock0(0), 17);

        start_i[0] = 1'b1; amt_i[0] = 8'd60;
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        chk("mid_cv_before_rst", cv[0], 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cv", cv[0], 0);
        chk("mid_rst_code", code[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_remaining", rem[0], 0);
        chk("mid_rst_stock1", stock0(0), 20);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(4'd4);
        payout(0, 8'd50, 1, 0, nd, nf, cvc, dat, fcv, b1, fwc);
        chk("post_rst_done", nd, 1);
        chk("post_rst_dispensed", disp[0], 50);
        chk("post_rst_stock50", stock0(3), 19);
        chk("post_rst_stock10", stock0(2), 20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change payout engine for the vending machine. It takes the change amount computed by the controller and drives the coin hopper one coin at a time, using coin codes of the same kind the coin detector decodes on input, so it is the output end of that path. It keeps a stock count per denomination, pays out greedily largest-first, and flags a fault if it runs short or the hopper stops responding. It runs on the system clock, alongside the controller.

## Interface
- REFILL_COUNT, 20: stock loaded into every denomination at reset and on refill; range 0..255.
- HOPPER_TIMEOUT, 1000: maximum cycles coin_valid may stay high without hopper_ack; range ≥1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; change_amount is latched when the block is idle.
- change_amount  in  8  amount to pay out, unsigned.
- refill  in  1  sets all four stock counters to REFILL_COUNT; honoured only while idle.
- hopper_ack  in  1  hopper accepted the presented coin; one cycle.
- coin_valid  out  1  a coin request is presented on coin_code.
- coin_code  out  4  denomination requested: 4'd1 = 1, 4'd2 = 5, 4'd3 = 10, 4'd4 = 50; 4'd0 when coin_valid is low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: payout completed exactly.
- fault  out  1  one-cycle pulse: payout aborted.
- fault_code  out  2  set with fault and held until the next accepted start: 0 = none, 1 = short (no coin fits), 2 = hopper timeout.
- remaining  out  8  amount still owed; held after done or fault until the next start.
- dispensed_total  out  8  value paid in the current or most recent payout.

## Operation
- States are IDLE, SELECT, ISSUE, DONE and FAULT.
- IDLE
  - refill loads the stock counters.
  - start latches remaining ← change_amount, clears dispensed_total and fault_code, and goes to SELECT.
  - If start and refill arrive in the same cycle, both act; SELECT then sees the refilled stock.
- SELECT (one cycle)
  - remaining == 0 → DONE.
  - Otherwise pick the largest denomination d with value(d) ≤ remaining and stock(d) > 0, and go to ISSUE with coin_code = d.
  - If no denomination qualifies → FAULT with fault_code = 1.
- ISSUE
  - coin_valid = 1, and coin_code stays stable until exit.
  - A timeout counter starts at 0 on entry.
  - hopper_ack = 1:
    - remaining −= value(d).
    - dispensed_total += value(d).
    - stock(d) −= 1.
    - go to SELECT.
  - No ack for HOPPER_TIMEOUT consecutive ISSUE cycles → FAULT with fault_code = 2. No counters change.
- DONE: done = 1 for one cycle, then IDLE.
- FAULT: fault = 1 for one cycle, then IDLE.
- Ignored inputs:
  - start while busy is dropped, not queued.
  - refill while busy is dropped.
  - hopper_ack outside ISSUE is ignored.
- Arithmetic:
  - All amounts are 8-bit unsigned.
  - remaining can never underflow, because value(d) ≤ remaining at selection.
  - dispensed_total ≤ change_amount, so it cannot overflow.
  - Stock counters are 8 bits and never decrement below 0, because a denomination is selected only when its stock is above 0.

## Timing
- Reset values:
  - State IDLE.
  - coin_valid, coin_code, busy, done, fault, fault_code, remaining, dispensed_total all 0.
  - Every stock counter = REFILL_COUNT.
- All outputs are registered.
- With start sampled at edge N:
  - busy = 1 from N+1.
  - The first coin_valid is at N+2.
- With hopper_ack sampled at edge M:
  - coin_valid = 0 at M+1 (SELECT).
  - The next coin_valid is at M+2.
  - The minimum is 2 cycles per coin.
- After the final ack at M: done at M+2, busy = 0 at M+3.
- change_amount = 0: done at N+2, coin_valid never asserts.
- A timeout triggers on the HOPPER_TIMEOUT-th ISSUE cycle without an ack. fault is high on the following cycle and coin_valid is low on that same cycle.
- rst_n low mid-payout: everything returns to reset values immediately and asynchronously, including stock reload. Any partial payout is forgotten.

## Test plan
- Payout of 67 with full stock: start with change_amount = 67, ack each coin 1 cycle after coin_valid.
  - Required: coin_code sequence 4,3,2,1,1; done pulses once; remaining = 0; dispensed_total = 67; stock(50), stock(10) and stock(5) each 19, stock(1) = 18.
- Zero amount: change_amount = 0.
  - Required: done exactly 2 cycles after start; coin_valid never high; dispensed_total = 0.
- Short payout with REFILL_COUNT = 1: start with 20.
  - Required: coin sequence 3,2,1, then fault with fault_code = 1; remaining = 4; dispensed_total = 16; a second start with 1 also faults short.
- Hopper timeout with HOPPER_TIMEOUT = 8: start with 5 and hold hopper_ack low.
  - Required: coin_valid high for exactly 8 cycles; fault with fault_code = 2; stock(5) unchanged; remaining = 5.
- Reset mid-payout: drop rst_n in ISSUE during a 60 payout.
  - Required: outputs at reset values at once; after release, a refill-free payout of 50 succeeds from full REFILL_COUNT stock.
- Ignored inputs: start with 11, then while busy pulse start with 99, pulse refill, and pulse a spurious hopper_ack outside ISSUE.
  - Required: only coins 3,1 issue; dispensed_total = 11; stock not reloaded.
